fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Consumes the current `pc`, issues one instruction-memory read per word and pulses `pc_update` when a request is accepted.
- Buffers returned words in a small FIFO and presents them with their addresses to decode over a valid/ready handshake.
- Supports a redirect flush that discards all buffered and in-flight fetches.

Parameters:
- FIFO_DEPTH, 2, number of instruction/PC entries buffered toward decode (power of two, >=2).
- ADDR_W, 32, width of `pc` and memory address.
- DATA_W, 32, instruction word width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising edge of clk.
- pc  input  ADDR_W  current program counter from PC stage.
- pc_update  output  1  one-cycle pulse; PC stage advances on next edge.
- flush  input  1  redirect: discard buffered and outstanding fetches.
- imem_req_valid  output  1  memory read request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  ADDR_W  request address.
- imem_rsp_valid  input  1  read data valid (no backpressure; at most one response per accepted request, in order).
- imem_rdata  input  DATA_W  read data.
- instr_valid  output  1  instruction available to decode.
- instr_ready  input  1  decode consumes instruction.
- instr  output  DATA_W  instruction word.
- instr_pc  output  ADDR_W  address of `instr`.

Behaviour:
- Reset (rst=0 at edge):
  - Outputs: pc_update=0, imem_req_valid=0, instr_valid=0, imem_addr=0, instr=0, instr_pc=0.
  - FIFO emptied, outstanding flag cleared, FSM to IDLE.
  - Reset mid-transaction discards any in-flight response.
- States:
  - IDLE: entered only from reset; moves to REQ after one cycle.
  - REQ:
    - imem_req_valid=1 iff (fifo_count + outstanding) < FIFO_DEPTH and flush=0; imem_addr=pc combinationally.
    - Handshake fires when imem_req_valid & imem_req_ready.
    - On handshake: pc_update=1 in the same cycle, capture pc into req_pc, go WAIT.
  - WAIT:
    - imem_req_valid=0.
    - On imem_rsp_valid: push {imem_rdata, req_pc} into FIFO, go REQ. Total latency, request accept to instr_valid, is one cycle after rsp_valid (registered FIFO output).
    - On flush with no same-cycle rsp_valid: go DRAIN.
    - On flush with same-cycle rsp_valid: the response is dropped; go REQ.
  - DRAIN: wait for the discarded response; on imem_rsp_valid drop data, go REQ. No requests are issued in DRAIN.
- At most one request outstanding at any time.
- Output handshake:
  - instr/instr_pc/instr_valid come from the FIFO head.
  - Pop when instr_valid & instr_ready.
  - Values stay stable while instr_valid=1 and instr_ready=0.
- Simultaneous push and pop in the same cycle is legal, including when the FIFO is full (count unchanged).
- Full: a request is never issued unless a slot is reserved, so no response is ever lost; a push to a full FIFO is unreachable. Assert this in simulation.
- Empty: instr_valid=0; instr and instr_pc hold their last values.
- Flush:
  - FIFO emptied at the edge; instr_valid=0 next cycle.
  - No request issued during the flush cycle, so pc_update=0 in that cycle.
  - The PC stage's own branch path supplies the new pc; fetch resumes from it the cycle after flush.
  - flush overrides push and pop in the same cycle.
- Address wrap: pc arithmetic is owned by the PC stage; fetch unit passes addresses through unmodified at all ADDR_W bits.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output `fetch_fault` (1 bit), reset 0.
  - In REQ, if pc[1:0] != 0, no memory request is issued. Instead, a FIFO entry {32'h0, pc} is pushed with a fault flag, and pc_update is not pulsed.
  - `fetch_fault` is asserted alongside instr_valid for that entry.
  - The FSM stalls in REQ (no further requests) until flush.
- Undefined: no port; pc[1:0] are ignored and the full pc is sent on imem_addr.

Decomposition:
- Shared package holds:
  - FETCH_ST_IDLE/REQ/WAIT/DRAIN state encoding typedef.
  - Default ADDR_W/DATA_W constants.
  - A fetch-entry struct {instr, pc, fault}.
- One sub-module, `fetch_fifo`: synchronous FIFO, depth FIFO_DEPTH, with push/pop/clear (flush), count, full, empty.

Test Plan:
- Reset then pc=0x0, imem_req_ready=1, 1-cycle memory latency, instr_ready=1 -> imem_addr 0x0, 0x4, 0x8 issued; pc_update pulses once per request; instr sequence matches rdata with instr_pc 0x0, 0x4, 0x8.
- instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH=2 words fetched, then imem_req_valid=0; releasing instr_ready delivers both in order, no loss.
- imem_req_ready=0 for 5 cycles at pc=0x20 -> imem_req_valid high, imem_addr stable 0x20, pc_update=0 throughout; accept on cycle 6 -> single pc_update pulse.
- flush in WAIT with response 3 cycles later, new pc=0x100 -> rdata of the dropped fetch never appears; next instr_pc=0x100; no request issued during DRAIN.
- rst=0 asserted while in WAIT with 1 FIFO entry -> next cycle instr_valid=0, imem_req_valid=0; the late rsp_valid after reset is ignored.
- With FETCH_ALIGN_CHECK_EN, pc=0x6 -> no imem request, instr_valid=1 with fetch_fault=1 and instr_pc=0x6; stays stalled until flush.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: FSM encoding, default widths, FIFO entry layout.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (see fetch_unit.sv).
package fetch_unit_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      FETCH_ST_IDLE,
      FETCH_ST_REQ,
      FETCH_ST_WAIT,
      FETCH_ST_DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] instr;
      logic [ADDR_W_DEF-1:0] pc;
      logic                  fault;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side handshakes of the fetch stage.
// master = fetch unit, slave = memory/decode environment.
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_rsp_valid;
   logic [DATA_W-1:0] imem_rdata;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;

   modport master (
      output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rdata, instr_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
      output imem_req_ready, imem_rsp_valid, imem_rdata, instr_ready
   );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO between memory responses and decode; clear empties it in one edge.
// The head output holds its last shown value while the FIFO is empty.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  entry_t                     push_data_i,
   input  logic                       pop_i,
   output entry_t                     head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   entry_t             mem_q [DEPTH];
   entry_t             last_q;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
      end else begin
         last_q <= head_o;
         if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, do_pop})
               2'b10:   count_q <= count_q + CNT_W'(1);
               2'b01:   count_q <= count_q - CNT_W'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // NOTE: the storage array is deliberately not reset; count_q alone decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues one imem read per word, buffers responses toward decode, handles redirect flush.
// Optional macro FETCH_ALIGN_CHECK_EN adds fetch_fault for misaligned pc.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_update,
   input  logic              flush,
   fetch_unit_if.master      bus
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic              fetch_fault
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [ADDR_W-1:0] pc;
`ifdef FETCH_ALIGN_CHECK_EN
      logic              fault;
`endif
   } entry_t;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              push, pop, fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   entry_t            push_entry, head;
   logic              outstanding, slot_free, fault_push, req_block;
   logic [CNT_W:0]    in_flight;

   // A slot is reserved for every outstanding read so a response can never find the FIFO full.
   assign outstanding = (state_q == FETCH_ST_WAIT) || (state_q == FETCH_ST_DRAIN);
   assign in_flight   = {1'b0, fifo_count} + (CNT_W + 1)'(outstanding);
   assign slot_free   = in_flight < DEPTH_V;
   assign pop         = bus.instr_valid && bus.instr_ready;

   assign bus.imem_addr   = (state_q == FETCH_ST_REQ) ? pc : '0;
   assign bus.instr_valid = !fifo_empty;
   assign bus.instr       = head.instr;
   assign bus.instr_pc    = head.pc;

`ifdef FETCH_ALIGN_CHECK_EN
   logic stall_q;
   logic misaligned;

   assign misaligned  = (pc[1:0] != 2'b00);
   assign fault_push  = (state_q == FETCH_ST_REQ) && misaligned && !stall_q && slot_free && !flush;
   assign req_block   = misaligned || stall_q;
   assign fetch_fault = bus.instr_valid && head.fault;

   always_ff @(posedge clk) begin
      if (!rst || flush) stall_q <= 1'b0;
      else if (fault_push) stall_q <= 1'b1;
   end
`else
   assign fault_push = 1'b0;
   assign req_block  = 1'b0;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d            = state_q;
      req_pc_d           = req_pc_q;
      bus.imem_req_valid = 1'b0;
      pc_update          = 1'b0;
      push               = 1'b0;
      push_entry         = '0;
      case (state_q)
         FETCH_ST_IDLE: state_d = FETCH_ST_REQ;
         FETCH_ST_REQ: begin
            bus.imem_req_valid = slot_free && !flush && !req_block;
            if (fault_push) begin
               push          = 1'b1;
               push_entry.pc = pc;
`ifdef FETCH_ALIGN_CHECK_EN
               push_entry.fault = 1'b1;
`endif
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
               pc_update = 1'b1;
               req_pc_d  = pc;
               state_d   = FETCH_ST_WAIT;
            end
         end
         FETCH_ST_WAIT: begin
            if (bus.imem_rsp_valid) begin
               push             = !flush;
               push_entry.instr = bus.imem_rdata;
               push_entry.pc    = req_pc_q;
               state_d          = FETCH_ST_REQ;
            end else if (flush) begin
               state_d = FETCH_ST_DRAIN;
            end
         end
         FETCH_ST_DRAIN: if (bus.imem_rsp_valid) state_d = FETCH_ST_REQ;
         default: state_d = FETCH_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= FETCH_ST_IDLE;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) assert (!(push && fifo_full && !pop));
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (flush),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: PC-stage and memory models, per-scenario tasks with inline checks.
// Build with FETCH_ALIGN_CHECK_EN to also exercise the misalignment fault path.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        pc_update;
   logic        flush;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fetch_fault;
`endif

   fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   fetch_unit #(.FIFO_DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .pc        (pc),
      .pc_update (pc_update),
      .flush     (flush),
      .bus       (bus)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .fetch_fault (fetch_fault)
`endif
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] req_log [$];
   logic [31:0] out_instr [$];
   logic [31:0] out_pc [$];
   logic [31:0] pc_tb;
   logic [31:0] pend_addr;
   logic [31:0] rdata_next;
   logic        pend;
   logic        rsp_next;
   int          cnt;
   int          mem_lat;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   // One cycle: log what the DUT shows now, advance PC/memory models, cross the edge, apply inputs.
   task automatic tick();
      logic acc;
      acc = (rst === 1'b1) && (bus.imem_req_valid === 1'b1) && (bus.imem_req_ready === 1'b1);
      if (rst === 1'b1) begin
         checks++;
         if (pc_update !== acc) begin
            errors++; $display("FAIL pc_update_pulse: got %b want %b", pc_update, acc);
         end
      end
      if (acc) begin
         checks++;
         if (pend || bus.imem_rsp_valid) begin
            errors++; $display("FAIL one_outstanding: addr 0x%h got 2 reads in flight want 1", bus.imem_addr);
         end
         req_log.push_back(bus.imem_addr);
      end
      if (pc_update === 1'b1) pc_tb += 32'd4;
      if (rst === 1'b1 && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
         out_instr.push_back(bus.instr);
         out_pc.push_back(bus.instr_pc);
      end
      rsp_next   = 1'b0;
      rdata_next = 32'hDEAD_BEEF;
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            pend = 1'b0; rsp_next = 1'b1; rdata_next = mem_word(pend_addr);
         end
      end
      if (acc) begin
         pend_addr = bus.imem_addr;
         if (mem_lat <= 1) begin
            rsp_next = 1'b1; rdata_next = mem_word(pend_addr);
         end else begin
            pend = 1'b1; cnt = mem_lat - 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      pc                 = pc_tb;
      bus.imem_rsp_valid = rsp_next;
      bus.imem_rdata     = rdata_next;
      #1;
   endtask

   task automatic set_pc(input logic [31:0] v);
      pc_tb = v; pc = v; #1;
   endtask

   task automatic run_until_out(input int n, input int budget, input string name);
      for (int k = 0; k < budget && out_instr.size() < n; k++) tick();
      checks++;
      if (out_instr.size() < n) begin
         errors++; $display("FAIL %s_timeout: got %0d instrs want %0d", name, out_instr.size(), n);
      end
   endtask

   task automatic apply_reset(input logic [31:0] start_pc);
      bus.imem_req_ready = 1'b0; bus.instr_ready = 1'b0; flush = 1'b0;
      for (int k = 0; k < 20 && (pend || bus.imem_rsp_valid); k++) tick();
      rst = 1'b0; tick(); tick(); rst = 1'b1;
      mem_lat = 1;
      req_log.delete(); out_instr.delete(); out_pc.delete();
      set_pc(start_pc);
   endtask

   task automatic test_reset();
      checks++; if (pc_update !== 1'b0) begin errors++; $display("FAIL rst_pc_update: got %b want 0", pc_update); end
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", bus.imem_req_valid); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid: got %b want 0", bus.instr_valid); end
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_imem_addr: got %h want 0", bus.imem_addr); end
      checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", bus.instr); end
      checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc: got %h want 0", bus.instr_pc); end
   endtask

   task automatic test_basic();
      logic [31:0] exp_a [3] = '{32'h0, 32'h4, 32'h8};
      logic [31:0] exp_i [3] = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008};
      apply_reset(32'h0);
      bus.instr_ready = 1'b1; bus.imem_req_ready = 1'b1; #1;
      tick();
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL basic_req_valid: got %b want 1", bus.imem_req_valid); end
      checks++; if (pc_update !== 1'b1) begin errors++; $display("FAIL basic_pc_update: got %b want 1", pc_update); end
      run_until_out(3, 40, "basic");
      bus.imem_req_ready = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (req_log[i] !== exp_a[i]) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", i, req_log[i], exp_a[i]); end
         checks++; if (out_instr[i] !== exp_i[i]) begin errors++; $display("FAIL basic_instr%0d: got %h want %h", i, out_instr[i], exp_i[i]); end
         checks++; if (out_pc[i] !== exp_a[i]) begin errors++; $display("FAIL basic_instr_pc%0d: got %h want %h", i, out_pc[i], exp_a[i]); end
      end
   endtask

   task automatic test_backpressure();
      apply_reset(32'h40);
      bus.imem_req_ready = 1'b1; #1;
      repeat (10) tick();
      checks++; if (req_log.size() != 2) begin errors++; $display("FAIL bp_req_count: got %0d want 2", req_log.size()); end
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", bus.imem_req_valid); end
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL bp_instr_valid: got %b want 1", bus.instr_valid); end
      checks++; if (bus.instr !== 32'hC0DE_0040) begin errors++; $display("FAIL bp_head_instr: got %h want C0DE0040", bus.instr); end
      checks++; if (bus.instr_pc !== 32'h40) begin errors++; $display("FAIL bp_head_pc: got %h want 40", bus.instr_pc); end
      bus.instr_ready = 1'b1; #1;
      run_until_out(2, 20, "bp");
      checks++; if (out_instr[0] !== 32'hC0DE_0040) begin errors++; $display("FAIL bp_out0: got %h want C0DE0040", out_instr[0]); end
      checks++; if (out_instr[1] !== 32'hC0DE_0044) begin errors++; $display("FAIL bp_out1: got %h want C0DE0044", out_instr[1]); end
      checks++; if (out_pc[1] !== 32'h44) begin errors++; $display("FAIL bp_out1_pc: got %h want 44", out_pc[1]); end
   endtask

   task automatic test_req_stall();
      apply_reset(32'h20);
      bus.instr_ready = 1'b1; #1;
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b want 1", i, bus.imem_req_valid); end
         checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("FAIL stall_addr%0d: got %h want 20", i, bus.imem_addr); end
         checks++; if (pc_update !== 1'b0) begin errors++; $display("FAIL stall_pc_update%0d: got %b want 0", i, pc_update); end
         tick();
      end
      bus.imem_req_ready = 1'b1; #1;
      checks++; if (pc_update !== 1'b1) begin errors++; $display("FAIL stall_accept_pulse: got %b want 1", pc_update); end
      tick();
      bus.imem_req_ready = 1'b0; #1;
      checks++; if (pc_update !== 1'b0) begin errors++; $display("FAIL stall_after_pulse: got %b want 0", pc_update); end
      checks++; if (req_log.size() != 1) begin errors++; $display("FAIL stall_req_count: got %0d want 1", req_log.size()); end
      checks++; if (req_log[0] !== 32'h20) begin errors++; $display("FAIL stall_req_addr: got %h want 20", req_log[0]); end
   endtask

   task automatic test_flush();
      int n0;
      apply_reset(32'h80);
      bus.imem_req_ready = 1'b1; #1;
      repeat (10) tick();
      flush = 1'b1; #1;
      tick();
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL flush_instr_valid: got %b want 0", bus.instr_valid); end
      checks++; if (bus.instr !== 32'hC0DE_0080) begin errors++; $display("FAIL flush_instr_hold: got %h want C0DE0080", bus.instr); end
      checks++; if (bus.instr_pc !== 32'h80) begin errors++; $display("FAIL flush_pc_hold: got %h want 80", bus.instr_pc); end
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_no_req: got %b want 0", bus.imem_req_valid); end
      checks++; if (pc_update !== 1'b0) begin errors++; $display("FAIL flush_no_pc_update: got %b want 0", pc_update); end
      flush = 1'b0; mem_lat = 4; bus.instr_ready = 1'b1;
      set_pc(32'h200);
      checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("FAIL flush_resume_addr: got %h want 200", bus.imem_addr); end
      n0 = req_log.size();
      tick();
      flush = 1'b1; #1;
      tick();
      flush = 1'b0;
      set_pc(32'h100);
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL drain_instr_valid: got %b want 0", bus.instr_valid); end
      run_until_out(1, 40, "flush");
      checks++; if (out_instr[0] !== 32'hC0DE_0100) begin errors++; $display("FAIL flush_first_instr: got %h want C0DE0100", out_instr[0]); end
      checks++; if (out_pc[0] !== 32'h100) begin errors++; $display("FAIL flush_first_pc: got %h want 100", out_pc[0]); end
      checks++; if (req_log[n0] !== 32'h200) begin errors++; $display("FAIL flush_req_a: got %h want 200", req_log[n0]); end
      checks++; if (req_log[n0+1] !== 32'h100) begin errors++; $display("FAIL flush_req_b: got %h want 100", req_log[n0+1]); end
   endtask

   task automatic test_reset_mid();
      apply_reset(32'h300);
      bus.imem_req_ready = 1'b1; #1;
      tick(); tick(); tick();
      mem_lat = 3;
      tick();
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", bus.instr_valid); end
      rst = 1'b0; bus.imem_req_ready = 1'b0; #1;
      tick();
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL mid_instr_valid: got %b want 0", bus.instr_valid); end
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_valid: got %b want 0", bus.imem_req_valid); end
      rst = 1'b1; #1;
      tick(); tick();
      repeat (3) begin
         checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL mid_late_rsp: got %b want 0", bus.instr_valid); end
         tick();
      end
      out_instr.delete(); out_pc.delete();
      mem_lat = 1; bus.imem_req_ready = 1'b1; bus.instr_ready = 1'b1;
      set_pc(32'h400);
      run_until_out(1, 20, "mid");
      checks++; if (out_instr[0] !== 32'hC0DE_0400) begin errors++; $display("FAIL mid_resume_instr: got %h want C0DE0400", out_instr[0]); end
      checks++; if (out_pc[0] !== 32'h400) begin errors++; $display("FAIL mid_resume_pc: got %h want 400", out_pc[0]); end
   endtask

`ifdef FETCH_ALIGN_CHECK_EN
   task automatic test_align();
      apply_reset(32'h6);
      bus.imem_req_ready = 1'b1; #1;
      tick();
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL align_no_req: got %b want 0", bus.imem_req_valid); end
      tick();
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL align_valid: got %b want 1", bus.instr_valid); end
      checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL align_fault: got %b want 1", fetch_fault); end
      checks++; if (bus.instr_pc !== 32'h6) begin errors++; $display("FAIL align_pc: got %h want 6", bus.instr_pc); end
      checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL align_instr: got %h want 0", bus.instr); end
      repeat (4) tick();
      checks++; if (req_log.size() != 0) begin errors++; $display("FAIL align_stalled: got %0d reqs want 0", req_log.size()); end
      flush = 1'b1; #1;
      tick();
      flush = 1'b0; bus.instr_ready = 1'b1;
      set_pc(32'h8);
      run_until_out(1, 20, "align");
      checks++; if (out_pc[0] !== 32'h8) begin errors++; $display("FAIL align_resume_pc: got %h want 8", out_pc[0]); end
   endtask
`endif

   initial begin
      rst = 1'b0; flush = 1'b0; pc = '0; pc_tb = '0;
      bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
      pend = 1'b0; cnt = 0; mem_lat = 1; pend_addr = '0; rsp_next = 1'b0; rdata_next = '0;
      tick(); tick();
      test_reset();
      test_basic();
      test_backpressure();
      test_req_stall();
      test_flush();
      test_reset_mid();
`ifdef FETCH_ALIGN_CHECK_EN
      test_align();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
